skew_seq: RTL and testbench

SKEW_SEQ -- requirements
Module: skew_seq

---
 rtl/skew_pkg.sv | 18 +
 rtl/skew_cnt.sv | 33 +++
 rtl/skew_seq.sv | 177 +++++++++++++++++
 tb/tb_skew_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/skew_pkg.sv
// Shared types for the skew sequencer: FSM state encoding and error codes.
// No ports; imported by skew_seq and skew_cnt.
package skew_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE = 2'b00;  // clean completion
  localparam err_t ERR_SKEW = 2'b01;  // requested offset below MIN_SKEW
  localparam err_t ERR_PREM = 2'b10;  // sync_in seen before en2 rose
  localparam err_t ERR_TMO  = 2'b11;  // sync_in never arrived after en2

endpackage

// File: rtl/skew_cnt.sv
// Clear/enable/saturating up-counter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        synchronous clear to zero (wins over en_i)
//   en_i         increment on this edge
//   cnt_nxt_c_o  combinational: saturated count+1, i.e. the value the counter
//                takes if enabled on the coming edge
module skew_cnt
  import skew_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_nxt_c_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q;

  // Saturating increment; holds at all-ones.
  assign cnt_nxt_c_o = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_nxt_c_o;
  end

endmodule

// File: rtl/skew_seq.sv
// Staggered two-enable sequencer: raises en1, then en2 'offset' edges later,
// then waits for sync_in and reports completion, violations and elapsed cycles.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      request a sequence (sampled only in IDLE), offset captured with it
//   sync_in    completion indication from the staggered path
//   en1, en2   leading / lagging enables
//   busy       state is not IDLE
//   done/viol  one-cycle completion / violation pulses
//   err_code   last outcome, held until the next done or viol
//   cycles     edges from en1 rise to sync sample, held until the next done
// Optional feature: define SKEW_SEQ_TIMEOUT_EN to abort WAIT after TIMEOUT edges.
module skew_seq
  import skew_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MIN_SKEW = 2,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] offset,
  input  logic             sync_in,
  output logic             en1,
  output logic             en2,
  output logic             busy,
  output logic             done,
  output logic             viol,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycles
);

`ifdef SKEW_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  err_t             err_q, err_d;
  logic             en1_q, en1_d, en2_q, en2_d;
  logic             busy_q, busy_d, done_q, done_d, viol_q, viol_d;

  logic             cyc_clr, cyc_en, tmo_clr, tmo_en, tmo_hit_c;
  logic [CNT_W-1:0] cyc_nxt_c, tmo_nxt_c;

  // Edges since en1 rose (stagger and cycles measurement).
  skew_cnt #(.CNT_W(CNT_W)) u_cyc (
    .clk(clk), .rst(rst), .clr_i(cyc_clr), .en_i(cyc_en), .cnt_nxt_c_o(cyc_nxt_c)
  );

  // Edges since en2 rose (timeout).
  skew_cnt #(.CNT_W(CNT_W)) u_tmo (
    .clk(clk), .rst(rst), .clr_i(tmo_clr), .en_i(tmo_en), .cnt_nxt_c_o(tmo_nxt_c)
  );

  assign tmo_hit_c = TmoEn && (32'(tmo_nxt_c) == TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      off_q    <= '0;
      cycles_q <= '0;
      err_q    <= ERR_NONE;
      en1_q    <= 1'b0;
      en2_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      viol_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
      en1_q    <= en1_d;
      en2_q    <= en2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      viol_q   <= viol_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    cycles_d = cycles_q;
    err_d    = err_q;
    en1_d    = en1_q;
    en2_d    = en2_q;
    done_d   = 1'b0;
    viol_d   = 1'b0;
    cyc_clr  = 1'b0;
    cyc_en   = 1'b0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        en1_d = 1'b0;
        en2_d = 1'b0;
        if (start) begin
          if (32'(offset) < MIN_SKEW) begin
            viol_d = 1'b1;
            err_d  = ERR_SKEW;
          end else begin
            off_d   = offset;
            cyc_clr = 1'b1;
            en1_d   = 1'b1;
            if (offset == '0) begin
              // Zero stagger: both enables rise together.
              en2_d   = 1'b1;
              tmo_clr = 1'b1;
              state_d = WAIT;
            end else begin
              state_d = LEAD;
            end
          end
        end
      end

      LEAD: begin
        cyc_en = 1'b1;
        if (sync_in) begin
          viol_d  = 1'b1;
          err_d   = ERR_PREM;
          en1_d   = 1'b0;
          state_d = IDLE;
        end else if (cyc_nxt_c == off_q) begin
          // This edge is the offset-th edge after en1 rose.
          en2_d   = 1'b1;
          tmo_clr = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        cyc_en = 1'b1;
        tmo_en = 1'b1;
        if (sync_in) begin
          done_d   = 1'b1;
          err_d    = ERR_NONE;
          cycles_d = cyc_nxt_c;
          en1_d    = 1'b0;
          en2_d    = 1'b0;
          state_d  = IDLE;
        end else if (tmo_hit_c) begin
          viol_d  = 1'b1;
          err_d   = ERR_TMO;
          en1_d   = 1'b0;
          en2_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        en1_d   = 1'b0;
        en2_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign en1      = en1_q;
  assign en2      = en2_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign viol     = viol_q;
  assign err_code = err_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_skew_seq.sv
// Directed self-checking bench for skew_seq (CNT_W=8, MIN_SKEW=2, TIMEOUT=16).
// Follows SKEW_SEQ_TIMEOUT_EN the same way the design does.
module tb_skew_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] offset;
  logic       sync_in;
  logic       en1, en2, busy, done, viol;
  logic [1:0] err_code;
  logic [7:0] cycles;

  int errors = 0;
  int checks = 0;

  skew_seq #(.CNT_W(8), .MIN_SKEW(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .offset(offset), .sync_in(sync_in),
    .en1(en1), .en2(en2), .busy(busy), .done(done), .viol(viol),
    .err_code(err_code), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; done and viol never coexist.
  task automatic tick();
    @(posedge clk);
    #1;
    check("done_viol_excl", 32'(done & viol), 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; offset = 8'd0; sync_in = 1'b0;
    ticks(2);
    // Reset state
    check("rst_en1", 32'(en1), 32'd0);
    check("rst_en2", 32'(en2), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_viol", 32'(viol), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    // rst has priority over start on the same edge
    start = 1'b1; offset = 8'd3;
    tick();
    check("rst_prio_en1", 32'(en1), 32'd0);
    check("rst_prio_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    // Reset mid-sequence (offset 5, rst 3 edges after en1 rise)
    start = 1'b1; offset = 8'd5;
    tick();
    start = 1'b0;
    check("abort_en1_up", 32'(en1), 32'd1);
    check("abort_busy", 32'(busy), 32'd1);
    ticks(3);
    check("abort_en2_low", 32'(en2), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_en1_async", 32'(en1), 32'd0);
    check("abort_busy_async", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_viol", 32'(viol), 32'd0);
    end
    check("abort_cycles", 32'(cycles), 32'd0);

    // Normal: offset 3, sync 2 edges after en2 -> cycles 5
    start = 1'b1; offset = 8'd3;
    tick();
    start = 1'b0;
    check("n_en1_rise", 32'(en1), 32'd1);
    check("n_en2_e0", 32'(en2), 32'd0);
    ticks(2);
    check("n_en2_e2", 32'(en2), 32'd0);
    tick();
    check("n_en2_e3", 32'(en2), 32'd1);
    tick();
    check("n_wait_done", 32'(done), 32'd0);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("n_done", 32'(done), 32'd1);
    check("n_cycles", 32'(cycles), 32'd5);
    check("n_err", 32'(err_code), 32'd0);
    check("n_en1_off", 32'(en1), 32'd0);
    check("n_en2_off", 32'(en2), 32'd0);
    check("n_busy_off", 32'(busy), 32'd0);
    tick();
    check("n_done_pulse", 32'(done), 32'd0);

    // start while busy is ignored; original offset 3 used, sync at E4 -> 4
    start = 1'b1; offset = 8'd3;
    tick();
    offset = 8'd9;
    ticks(2);
    start = 1'b0;
    check("busy_en2_e2", 32'(en2), 32'd0);
    tick();
    check("busy_en2_e3", 32'(en2), 32'd1);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("busy_done", 32'(done), 32'd1);
    check("busy_cycles", 32'(cycles), 32'd4);
    tick();

    // Offset below MIN_SKEW
    start = 1'b1; offset = 8'd1;
    tick();
    start = 1'b0;
    check("skew_viol", 32'(viol), 32'd1);
    check("skew_err", 32'(err_code), 32'd1);
    check("skew_en1", 32'(en1), 32'd0);
    check("skew_busy", 32'(busy), 32'd0);
    check("skew_cycles_held", 32'(cycles), 32'd4);
    tick();
    check("skew_viol_pulse", 32'(viol), 32'd0);
    check("skew_err_held", 32'(err_code), 32'd1);
    check("skew_en1_stay", 32'(en1), 32'd0);

    // Premature sync: offset 4, sync 2 edges after en1 rise
    start = 1'b1; offset = 8'd4;
    tick();
    start = 1'b0;
    tick();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    check("prem_viol", 32'(viol), 32'd1);
    check("prem_err", 32'(err_code), 32'd2);
    check("prem_en1", 32'(en1), 32'd0);
    check("prem_en2", 32'(en2), 32'd0);
    check("prem_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("prem_en2_never", 32'(en2), 32'd0);
    end

    // Timeout: offset 2, sync held low
    start = 1'b1; offset = 8'd2;
    tick();
    start = 1'b0;
    ticks(2);
    check("tmo_en2_rise", 32'(en2), 32'd1);
`ifdef SKEW_SEQ_TIMEOUT_EN
    ticks(15);
    check("tmo_viol_early", 32'(viol), 32'd0);
    check("tmo_busy_early", 32'(busy), 32'd1);
    tick();
    check("tmo_viol", 32'(viol), 32'd1);
    check("tmo_err", 32'(err_code), 32'd3);
    check("tmo_en1", 32'(en1), 32'd0);
    check("tmo_en2", 32'(en2), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_cycles_held", 32'(cycles), 32'd4);
    tick();
    check("tmo_viol_pulse", 32'(viol), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check("notmo_busy", 32'(busy), 32'd1);
      check("notmo_viol", 32'(viol), 32'd0);
    end
    check("notmo_err", 32'(err_code), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("notmo_rst_busy", 32'(busy), 32'd0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
